// File: rtl/ws2812_frame_arbiter_pkg.sv
// Shared types and constants for the WS2812 frame arbiter.
// Build option: WS_ARB_RST_ALIGN_EN aligns table fills to the WS2812 reset code.
package ws2812_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      WAIT_RST,
      FILL,
      UPD,
      DONE
   } arb_state_e;

   localparam int PIX_W           = 24;
   localparam int TIMEOUT_CYC_DEF = 1000000;

   // $clog2 that never returns 0, so single-entry tables/requesters keep a 1-bit index
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2812_frame_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
// Build option: none.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
            o_any                           = 1'b1;
            o_grant[(int'(i_ptr) + k) % N]  = 1'b1;
            o_idx                           = IDX_W'((int'(i_ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Round-robin frame arbiter feeding the WS2812 LED table RAM and update handshake.
// Build option: WS_ARB_RST_ALIGN_EN holds fills in WAIT_RST until rst_code is high.
//
// state    | meaning
// IDLE     | no frame in progress, waiting for any req
// ARB      | pick winner, latch grant, clear pix_addr
// WAIT_RST | (option) wait for WS2812 reset code before filling
// FILL     | stream LED_NUM pixels from the winner into the table
// UPD      | update_reqeust high until update_done or timeout
// DONE     | pulse frame_done, advance pointer, release grant
module ws2812_frame_arbiter
   import ws2812_pkg::*;
#(
   parameter int LED_NUM     = 4,
   parameter int ADDR_BIT    = clog2_min1(LED_NUM),
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NUM_REQ-1:0]       req,
   output logic [NUM_REQ-1:0]       grant,
   output logic [ADDR_BIT-1:0]      pix_addr,
   input  logic [NUM_REQ*PIX_W-1:0] pix_data,
   output logic [NUM_REQ-1:0]       frame_done,
   output logic                     ram_wrclock,
   output logic [ADDR_BIT-1:0]      ram_wraddress,
   output logic [PIX_W-1:0]         ram_data,
   output logic                     update_reqeust,
   input  logic                     update_done,
   input  logic                     rst_code,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int IDX_W = clog2_min1(NUM_REQ);
   localparam int CNT_W = ADDR_BIT + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   arb_state_e           r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_pick_oh;
   logic [IDX_W-1:0]     r_gnt_idx, r_ptr, w_pick_idx;
   logic                 w_pick_any;
   logic [ADDR_BIT-1:0]  r_pix_addr, r_wraddr;
   logic [PIX_W-1:0]     r_wdata, w_sel_pix;
   logic [CNT_W-1:0]     r_fill_cnt;
   logic [TMR_W-1:0]     r_tmr;
   logic                 r_tmo_err;
   logic                 w_fill_last, w_tmr_tc;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_oh),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_sel_pix   = pix_data[int'(r_gnt_idx) * PIX_W +: PIX_W];
   assign w_fill_last = (r_fill_cnt == CNT_W'(LED_NUM));
   assign w_tmr_tc    = (r_tmr == '0);

`ifndef WS_ARB_RST_ALIGN_EN
   logic w_unused_rst_code;
   assign w_unused_rst_code = rst_code;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      busy           = (r_state != IDLE);
      update_reqeust = (r_state == UPD);
      frame_done     = (r_state == DONE) ? r_grant : '0;
      case (r_state)
         IDLE:     if (|req) w_state_nxt = ARB;
`ifdef WS_ARB_RST_ALIGN_EN
         ARB:      w_state_nxt = w_pick_any ? WAIT_RST : IDLE;
         WAIT_RST: if (rst_code) w_state_nxt = FILL;
`else
         ARB:      w_state_nxt = w_pick_any ? FILL : IDLE;
         WAIT_RST: w_state_nxt = FILL;
`endif
         FILL:     if (w_fill_last) w_state_nxt = UPD;
         UPD:      if (update_done || w_tmr_tc) w_state_nxt = DONE;
         DONE:     w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_grant    <= '0;
         r_gnt_idx  <= '0;
         r_ptr      <= '0;
         r_pix_addr <= '0;
         r_fill_cnt <= '0;
         r_wraddr   <= '0;
         r_wdata    <= '0;
         r_tmr      <= '0;
         r_tmo_err  <= 1'b0;
      end else begin
         if (r_state == ARB && w_pick_any) begin
            r_grant    <= w_pick_oh;
            r_gnt_idx  <= w_pick_idx;
            r_pix_addr <= '0;
            r_fill_cnt <= '0;
         end
         // write regs trail pix_addr by one cycle to match the source's read latency
         if (r_state == FILL) begin
            if (r_pix_addr != ADDR_BIT'(LED_NUM - 1)) r_pix_addr <= r_pix_addr + 1'b1;
            if (r_fill_cnt != '0) begin
               r_wraddr <= ADDR_BIT'(r_fill_cnt - 1'b1);
               r_wdata  <= w_sel_pix;
            end
            if (!w_fill_last) r_fill_cnt <= r_fill_cnt + 1'b1;
            r_tmr <= TMR_W'(TIMEOUT_CYC - 1);
         end
         if (r_state == UPD) begin
            if (!w_tmr_tc) r_tmr <= r_tmr - 1'b1;
            if (!update_done && w_tmr_tc) r_tmo_err <= 1'b1;
         end
         if (r_state == DONE) begin
            r_grant <= '0;
            r_ptr   <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
         end
      end
   end

   assign grant         = r_grant;
   assign pix_addr      = r_pix_addr;
   assign ram_wrclock   = CLK;
   assign ram_wraddress = r_wraddr;
   assign ram_data      = r_wdata;
   assign timeout_err   = r_tmo_err;

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Self-checking bench: directed scenarios plus random requests against a frame-level model.
// Build option: WS_ARB_RST_ALIGN_EN enables the reset-code alignment scenario.
module tb_ws2812_frame_arbiter;

   localparam int LED_NUM = 4;
   localparam int NUM_REQ = 2;
   localparam int TMO     = 50;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [1:0]  req = '0;
   logic [47:0] pix_data = '0;
   logic        update_done = 1'b0;
   logic        rst_code = 1'b1;
   logic [1:0]  grant, frame_done, pix_addr, ram_wraddress;
   logic [23:0] ram_data;
   logic        ram_wrclock, update_reqeust, busy, timeout_err;

   ws2812_frame_arbiter #(
      .LED_NUM(LED_NUM), .NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TMO)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .req(req), .grant(grant), .pix_addr(pix_addr),
      .pix_data(pix_data), .frame_done(frame_done), .ram_wrclock(ram_wrclock),
      .ram_wraddress(ram_wraddress), .ram_data(ram_data),
      .update_reqeust(update_reqeust), .update_done(update_done),
      .rst_code(rst_code), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [1:0] r, input int p);
      for (int k = 0; k < NUM_REQ; k++)
         if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      return -1;
   endfunction

   // sources: registered read, data valid the cycle after pix_addr
   logic [23:0] salt [NUM_REQ];
   always @(posedge CLK)
      for (int i = 0; i < NUM_REQ; i++) pix_data[i*24 +: 24] <= salt[i] + 24'(pix_addr);

   // WS2812 side: answer update_reqeust after ud_delay cycles, or never
   bit rnd_ud = 0, ud_never = 0;
   int ud_delay = 0, ud_cnt = 0;
   always begin
      @(posedge CLK); #1;
      if (!update_reqeust) begin
         ud_cnt = 0;
         update_done = 1'b0;
      end else begin
         if (ud_cnt == 0 && rnd_ud) begin
            ud_delay = $urandom_range(0, 7);
            ud_never = ($urandom_range(0, 9) == 0);
         end
         update_done = !ud_never && (ud_cnt >= ud_delay);
         ud_cnt++;
      end
   end

   // frame-level reference model
   bit          fixed_salt = 0;
   bit          act = 0, err_m = 0, fill_known = 0;
   int          cyc = 0, ptr = 0, win = 0, fill_start = 0, cyc_upd = 0, exp_done = -1;
   logic [1:0]  prev_grant = '0, prev_req = '0, exp_fd, exp_g;
   logic        prev_upd = 1'b0;
   logic [23:0] mem [LED_NUM];
   logic [23:0] exp_salt = '0;
   logic [25:0] last_w = '0;
   logic [25:0] wlog [$];

   always @(negedge CLK) begin
      if (!RST_N) begin
         act = 0; err_m = 0; ptr = 0; exp_done = -1; fill_known = 0;
         prev_grant = '0; prev_req = '0; prev_upd = 1'b0; last_w = '0;
      end else begin
         cyc++;
         mem[ram_wraddress] = ram_data;
         if ({ram_wraddress, ram_data} != last_w) begin
            last_w = {ram_wraddress, ram_data};
            wlog.push_back(last_w);
         end
         if (prev_grant == 2'b00 && grant != 2'b00) begin
            win   = rr_pick(prev_req, ptr);
            exp_g = (win < 0) ? 2'b00 : (2'b01 << win);
            check("grant", grant, exp_g);
            check("pix0", pix_addr, 0);
            if (win < 0) win = 0;
            act      = 1;
            exp_salt = fixed_salt ? 24'h100000 : 24'($urandom);
            salt[win] = exp_salt;
`ifdef WS_ARB_RST_ALIGN_EN
            fill_known = 0;
`else
            fill_known = 1;
            fill_start = cyc;
`endif
         end else if (act) begin
            check("grant_hold", grant, 2'b01 << win);
         end
         if (act && !fill_known && rst_code) begin
            fill_known = 1;
            fill_start = cyc + 1;
         end
         if (update_reqeust && !prev_upd) begin
            check("upd_lat", cyc - fill_start, LED_NUM + 1);
            cyc_upd = cyc;
         end
         if (act && update_reqeust && exp_done < 0) begin
            if (update_done) exp_done = cyc + 1;
            else if (cyc - cyc_upd == TMO - 1) begin
               exp_done = cyc + 1;
               err_m    = 1;
            end
         end
         exp_fd = (act && cyc == exp_done) ? (2'b01 << win) : 2'b00;
         check("fdone", frame_done, exp_fd);
         if (act && cyc == exp_done) begin
            check("upd_drop", update_reqeust, 0);
            check("tmo_err", timeout_err, err_m);
            for (int a = 0; a < LED_NUM; a++) check("table", mem[a], exp_salt + 24'(a));
            ptr      = (win + 1) % NUM_REQ;
            act      = 0;
            exp_done = -1;
         end
         prev_grant = grant;
         prev_req   = req;
         prev_upd   = update_reqeust;
      end
   end

   task automatic wait_fd(input int budget, output logic [1:0] fd);
      fd = '0;
      for (int i = 0; i < budget; i++) begin
         @(posedge CLK); #1;
         if (frame_done != 2'b00) begin
            fd = frame_done;
            return;
         end
      end
      check("wait_fd_expired", 1, 0);
   endtask

   task automatic wait_grant(input logic [1:0] mask, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge CLK); #1;
         if ((grant & mask) != 2'b00) return;
      end
      check("wait_grant_expired", 1, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [1:0]  fd, prev_fd;
   logic [1:0]  wa_hold;
   bit          hit;

   initial begin
      for (int i = 0; i < NUM_REQ; i++) salt[i] = '0;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_grant", grant, 0);
      check("rst_fdone", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_upd", update_reqeust, 0);
      check("rst_tmo", timeout_err, 0);
      check("rst_pix", pix_addr, 0);
      check("rst_wa", ram_wraddress, 0);
      check("rst_wd", ram_data, 0);
      check("rst_wrclk", ram_wrclock, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;

      // single frame from source 0 with known data
      fixed_salt = 1; ud_delay = 5;
      wlog.delete();
      req = 2'b01;
      wait_fd(100, fd);
      req = 2'b00;
      check("a_fd", fd, 2'b01);
      check("a_nwr", wlog.size(), LED_NUM);
      for (int a = 0; a < LED_NUM; a++)
         if (a < wlog.size()) check("a_wr", wlog[a], {2'(a), 24'h100000 + 24'(a)});
      fixed_salt = 0;

      // both requesting continuously: grants must alternate
      ud_delay = 2;
      req = 2'b11;
      prev_fd = '0;
      for (int k = 0; k < 4; k++) begin
         wait_fd(100, fd);
         if (k > 0) check("b_alt", fd ^ prev_fd, 2'b11);
         prev_fd = fd;
      end
      req = 2'b00;

      // update_done never comes
      ud_never = 1;
      req = 2'b01;
      wait_fd(200, fd);
      req = 2'b00;
      check("c_fd", fd, 2'b01);
      check("c_tmo", timeout_err, 1);
      repeat (5) @(posedge CLK);
      #1;
      check("c_sticky", timeout_err, 1);
      ud_never = 0;

      // reset in the middle of FILL
      ud_delay = 3;
      req = 2'b01;
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(posedge CLK); #1;
         if (busy && grant != 2'b00 && pix_addr == 2'd2) hit = 1;
      end
      check("d_reach", hit, 1);
      RST_N = 1'b0;
      #1;
      check("d_grant", grant, 0);
      check("d_upd", update_reqeust, 0);
      check("d_busy", busy, 0);
      check("d_tmo", timeout_err, 0);
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      wait_fd(100, fd);
      req = 2'b00;
      check("d_fd", fd, 2'b01);

      // granted source withdraws its request right after grant
      req = 2'b10;
      wait_grant(2'b10, 50);
      @(posedge CLK); #1;
      req[1] = 1'b0;
      wait_fd(100, fd);
      check("e_fd", fd, 2'b10);

`ifdef WS_ARB_RST_ALIGN_EN
      rst_code = 1'b0;
      req = 2'b01;
      wait_grant(2'b01, 50);
      wa_hold = ram_wraddress;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         check("f_wa_hold", ram_wraddress, wa_hold);
      end
      rst_code = 1'b1;
      wait_fd(100, fd);
      req = 2'b00;
      check("f_fd", fd, 2'b01);
`endif

      // random traffic
      rnd_ud = 1;
      for (int c = 0; c < 2000; c++) begin
         @(posedge CLK); #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (frame_done[i]) req[i] = 1'b0;
            else if (grant[i] && req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
            else if (!req[i] && !grant[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
         end
      end
      req = 2'b00;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge CLK); #1;
         if (!busy) hit = 1;
      end
      check("idle_end", hit, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
